// File: rtl/cnt_capture_pkg.sv
// cnt_capture_pkg: shared types and defaults for the counter capture block
package cnt_capture_pkg;
    localparam int DEFAULT_CNT_W = 8;
    typedef struct packed {
        logic [DEFAULT_CNT_W-1:0] data;
        logic [DEFAULT_CNT_W-1:0] delta;
    } cap_entry_t;
endpackage

// File: rtl/cnt_capture_if.sv
// cnt_capture_if: valid/ready stream carrying timestamp and delta
interface cnt_capture_if import cnt_capture_pkg::*; #(parameter int W = DEFAULT_CNT_W);
    logic [W-1:0] data;
    logic [W-1:0] delta;
    logic         valid;
    logic         ready;
    modport master (output data, delta, valid, input ready);
    modport slave  (input data, delta, valid, output ready);
endinterface

// File: rtl/cnt_capture_fifo.sv
// cnt_capture_fifo: show-ahead synchronous FIFO with extra-MSB pointers
module cnt_capture_fifo import cnt_capture_pkg::*; #(
    parameter int  DEPTH = 4,
    parameter type T     = cap_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    T           mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/cnt_capture.sv
// cnt_capture: timestamps trigger rising edges with modular delta into a FIFO
module cnt_capture import cnt_capture_pkg::*; #(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int DEPTH   = 4,
    parameter bit INC_DEC = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT_W-1:0]       cnt_i,
    input  logic                   trig_i,
    input  logic                   clr_ovf_i,
    cnt_capture_if.master          out,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    typedef struct packed {
        logic [CNT_W-1:0] data;
        logic [CNT_W-1:0] delta;
    } entry_t;
    logic             trig_d, first, rise, push, pop, drop, full, empty;
    logic [CNT_W-1:0] last_cap, delta;
    entry_t           head;
    assign rise  = trig_i & ~trig_d;
    assign pop   = ~empty & out.ready;
    assign push  = rise & (~full | pop);
    assign drop  = rise & full & ~pop;
    assign delta = first ? '0 : INC_DEC ? cnt_i - last_cap : last_cap - cnt_i;
    assign out.valid = ~empty;
    assign out.data  = head.data;
    assign out.delta = head.delta;
    // trig_d resets high so a trigger already asserted at reset release is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d   <= 1'b1;
            first    <= 1'b1;
            last_cap <= '0;
            overflow <= 1'b0;
        end else begin
            trig_d   <= trig_i;
            overflow <= drop | (overflow & ~clr_ovf_i);
            if (push) begin
                last_cap <= cnt_i;
                first    <= 1'b0;
            end
        end
    end
    cnt_capture_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ('{data: cnt_i, delta: delta}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
`ifdef ASSERTS_SV
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_level_max:    assert property (@(posedge clk) disable iff (!rst_n) level <= DEPTH);
    a_valid_known:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(out.valid));
    a_head_hold:    assert property (@(posedge clk) disable iff (!rst_n)
                        out.valid && !out.ready |=> $stable(out.data) && $stable(out.delta));
`endif
endmodule
